// File: rtl/arb2_mux_sel_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream 2:1 mux.
// When ARB2_LOCK_EN is defined, the bundle also carries the a_last/b_last burst markers.
interface arb2_mux_sel_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sel;
`ifdef ARB2_LOCK_EN
  logic             a_last;
  logic             b_last;

  modport master (
    output a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
    input  a_ready, b_ready, out_data, out_valid, sel
  );

  modport slave (
    input  a_data, a_valid, a_last, b_data, b_valid, b_last, out_ready,
    output a_ready, b_ready, out_data, out_valid, sel
  );
`else
  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_valid, sel
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_valid, sel
  );
`endif
endinterface

// File: rtl/arb2_mux_sel.sv
// Two-requester round-robin arbiter. It registers the winning beat and publishes
// sel, so the downstream 2:1 mux and out_data stay aligned.
// Optional feature macro ARB2_LOCK_EN: when it is defined, each grant locks onto
// its owner until the owner's accepted beat carries last=1.
module arb2_mux_sel #(
  parameter int WIDTH     = 8,
  parameter bit PRIO_INIT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  arb2_mux_sel_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD_A = 2'd1, HOLD_B = 2'd2} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_p1;
  logic             sel_p1;
  logic             prio_q;
  logic             grant_a;
  logic             grant_b;
  logic             can_accept;
  logic             a_rdy;
  logic             b_rdy;
  logic             vld_p1;
  logic             a_fire;
  logic             b_fire;
  logic             win_last;
`ifdef ARB2_LOCK_EN
  logic             lock_q;
  logic             owner_q;
`endif

  assign can_accept = (state_q == IDLE) | bus.out_ready;
  assign a_fire     = a_rdy;
  assign b_fire     = b_rdy;

  // Grant selection: a held lock wins outright, otherwise round-robin on prio.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
`ifdef ARB2_LOCK_EN
    if (lock_q) begin
      grant_a = ~owner_q & bus.a_valid;
      grant_b =  owner_q & bus.b_valid;
    end else begin
      grant_a = bus.a_valid & (~bus.b_valid | ~prio_q);
      grant_b = bus.b_valid & (~bus.a_valid |  prio_q);
    end
`else
    grant_a = bus.a_valid & (~bus.b_valid | ~prio_q);
    grant_b = bus.b_valid & (~bus.a_valid |  prio_q);
`endif
  end

  // Last-beat marker of the beat being accepted; without locking every beat ends a burst.
  always_comb begin
    win_last = 1'b1;
`ifdef ARB2_LOCK_EN
    win_last = b_fire ? bus.b_last : bus.a_last;
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a new beat loads, a consumed beat with no replacement empties the holder.
  always_comb begin
    state_d = state_q;
    if (a_fire)             state_d = HOLD_A;
    else if (b_fire)        state_d = HOLD_B;
    else if (bus.out_ready) state_d = IDLE;
  end

  // FSM outputs: readies are held low during reset so that no beat is taken while rst is high.
  always_comb begin
    vld_p1 = (state_q != IDLE);
    a_rdy  = ~rst & can_accept & grant_a;
    b_rdy  = ~rst & can_accept & grant_b;
  end

  // Stage p1: capture the winner's payload and id, and mux only on a granted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      sel_p1  <= 1'b0;
    end else if (a_fire) begin
      data_p1 <= bus.a_data;
      sel_p1  <= 1'b0;
    end else if (b_fire) begin
      data_p1 <= bus.b_data;
      sel_p1  <= 1'b1;
    end
  end

  // Round-robin pointer (and lock ownership): favour the loser once a burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= PRIO_INIT;
`ifdef ARB2_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
`endif
    end else if (a_fire | b_fire) begin
      if (win_last) prio_q <= ~b_fire;
`ifdef ARB2_LOCK_EN
      lock_q  <= ~win_last;
      owner_q <= b_fire;
`endif
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.sel       = sel_p1;

endmodule

// File: tb/tb_arb2_mux_sel.sv
// Self-checking bench for arb2_mux_sel, driven through a scoreboard of expected beats.
module tb_arb2_mux_sel;

  localparam int WIDTH     = 8;
  localparam bit PRIO_INIT = 1'b0;
`ifdef ARB2_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arb2_mux_sel_if #(.WIDTH(WIDTH)) bus();

  arb2_mux_sel #(.WIDTH(WIDTH), .PRIO_INIT(PRIO_INIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             s;
    logic [WIDTH-1:0] d;
  } beat_t;

  beat_t sb[$];
  int    checks   = 0;
  int    failures = 0;
  logic  m_prio   = PRIO_INIT;
  logic  m_lock   = 1'b0;
  logic  m_owner  = 1'b0;

  // Run one clock cycle: drive the inputs, check the readies against the model,
  // advance across the edge, then check the output against the scoreboard head.
  task automatic step(input logic r, input logic av, input logic [WIDTH-1:0] ad, input logic al,
                      input logic bv, input logic [WIDTH-1:0] bd, input logic bl, input logic ordy,
                      output logic got_ar, output logic got_br);
    logic ga, gb, ea, eb, lst;
    beat_t bt;
    rst           = r;
    bus.a_valid   = av;
    bus.a_data    = ad;
    bus.b_valid   = bv;
    bus.b_data    = bd;
    bus.out_ready = ordy;
`ifdef ARB2_LOCK_EN
    bus.a_last    = al;
    bus.b_last    = bl;
`endif
    #1;
    if (m_lock) begin
      ga = av & ~m_owner;
      gb = bv &  m_owner;
    end else begin
      ga = av & (~bv | ~m_prio);
      gb = bv & (~av |  m_prio);
    end
    ea = ~r & ((sb.size() == 0) | ordy) & ga;
    eb = ~r & ((sb.size() == 0) | ordy) & gb;
    got_ar = bus.a_ready;
    got_br = bus.b_ready;
    checks++;
    if (bus.a_ready !== ea) begin
      failures++;
      $display("FAIL a_ready t=%0t got=%b exp=%b", $time, bus.a_ready, ea);
    end
    checks++;
    if (bus.b_ready !== eb) begin
      failures++;
      $display("FAIL b_ready t=%0t got=%b exp=%b", $time, bus.b_ready, eb);
    end
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_prio  = PRIO_INIT;
      m_lock  = 1'b0;
      m_owner = 1'b0;
    end else begin
      if (sb.size() != 0 && ordy) void'(sb.pop_front());
      if (ea | eb) begin
        bt.s = eb;
        bt.d = eb ? bd : ad;
        sb.push_back(bt);
        lst = LOCK ? (eb ? bl : al) : 1'b1;
        if (lst) m_prio = ~eb;
        m_lock  = ~lst;
        m_owner = eb;
      end
    end
    checks++;
    if (bus.out_valid !== (sb.size() != 0)) begin
      failures++;
      $display("FAIL out_valid t=%0t got=%b exp=%b", $time, bus.out_valid, (sb.size() != 0));
    end
    if (sb.size() != 0) begin
      checks++;
      if (bus.out_data !== sb[0].d || bus.sel !== sb[0].s) begin
        failures++;
        $display("FAIL sb_beat t=%0t got=%h/%b exp=%h/%b", $time, bus.out_data, bus.sel, sb[0].d, sb[0].s);
      end
    end
  endtask

  task automatic test_reset();
    logic ar, br;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 8'hAA, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b1, ar, br);
      checks++;
      if (bus.out_data !== 8'h00 || bus.sel !== 1'b0) begin
        failures++;
        $display("FAIL reset_out got=%h/%b exp=00/0", bus.out_data, bus.sel);
      end
    end
  endtask

  task automatic test_single_a();
    logic ar, br;
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, ar, br);
    checks++;
    if (ar !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'h5A || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL single_a got=%b/%b/%h/%b exp=1/1/5a/0", ar, bus.out_valid, bus.out_data, bus.sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, ar, br);
  endtask

  task automatic test_fairness();
    logic ar, br;
    logic [WIDTH-1:0] exp_d;
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, ar, br);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, ar, br);
      exp_d = (k % 2 == 0) ? 8'h11 : 8'h22;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.sel !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL fair_%0d got=%b/%h/%b exp=1/%h/%b", k, bus.out_valid, bus.out_data, bus.sel, exp_d, (k % 2 == 1));
      end
    end
  endtask

  task automatic test_stall();
    logic ar, br;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, ar, br);
      checks++;
      if (ar !== 1'b0 || br !== 1'b0 || bus.out_data !== 8'h22 || bus.sel !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d got=%b/%b/%h/%b exp=0/0/22/1", k, ar, br, bus.out_data, bus.sel);
      end
    end
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, ar, br);
    checks++;
    if (bus.out_data !== 8'h11 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got=%h/%b exp=11/0", bus.out_data, bus.sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, ar, br);
  endtask

  task automatic test_reset_hold();
    logic ar, br;
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, ar, br);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, ar, br);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold got=%b exp=0", bus.out_valid);
    end
    step(1'b0, 1'b1, 8'h44, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, ar, br);
    checks++;
    if (bus.out_data !== 8'h44 || bus.sel !== 1'b0) begin
      failures++;
      $display("FAIL reset_prio got=%h/%b exp=44/0", bus.out_data, bus.sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, ar, br);
  endtask

`ifdef ARB2_LOCK_EN
  task automatic test_lock();
    logic ar, br;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, ar, br);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'hA1 + k[7:0], (k == 2), 1'b1, 8'hB1, 1'b1, 1'b1, ar, br);
      checks++;
      if (ar !== 1'b1 || br !== 1'b0) begin
        failures++;
        $display("FAIL lock_%0d got=%b/%b exp=1/0", k, ar, br);
      end
    end
    step(1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b1, ar, br);
    checks++;
    if (bus.out_data !== 8'hB1 || bus.sel !== 1'b1) begin
      failures++;
      $display("FAIL lock_release got=%h/%b exp=b1/1", bus.out_data, bus.sel);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, ar, br);
  endtask
`endif

  initial begin
    bus.a_valid   = 1'b0;
    bus.a_data    = '0;
    bus.b_valid   = 1'b0;
    bus.b_data    = '0;
    bus.out_ready = 1'b0;
`ifdef ARB2_LOCK_EN
    bus.a_last    = 1'b1;
    bus.b_last    = 1'b1;
`endif
    test_reset();
    test_single_a();
    test_fairness();
    test_stall();
    test_reset_hold();
`ifdef ARB2_LOCK_EN
    test_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
